// File: rtl/sysid_arbiter.sv
// ============================================================================
// Module   : sysid_arbiter
// Brief    : Round-robin arbiter sharing one sysid control slave between two
//            read-only requesters, with ID check and transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysid_arbiter #(
    parameter logic [31:0] EXPECTED_ID = 32'd1715151045
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_read,
    input  logic        m0_address,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic        m1_read,
    input  logic        m1_address,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        s_address,
    input  logic [31:0] s_readdata,
    output logic        busy,
    output logic        id_mismatch,
    output logic [15:0] xfer_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        s_address_q, s_address_d;
    logic [31:0] data_q, data_d;
    logic [31:0] m0_rd_q, m0_rd_d;
    logic [31:0] m1_rd_q, m1_rd_d;
    logic        mismatch_q, mismatch_d;
    logic [15:0] count_q, count_d;
    logic        winner;
    logic        resp0, resp1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            s_address_q  <= 1'b0;
            data_q       <= 32'd0;
            m0_rd_q      <= 32'd0;
            m1_rd_q      <= 32'd0;
            mismatch_q   <= 1'b0;
            count_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            s_address_q  <= s_address_d;
            data_q       <= data_d;
            m0_rd_q      <= m0_rd_d;
            m1_rd_q      <= m1_rd_d;
            mismatch_q   <= mismatch_d;
            count_q      <= count_d;
        end
    end

    // On a tie the requester that was not served last wins.
    always_comb begin
        winner = 1'b0;
        if (m0_read && m1_read) begin
            winner = ~last_grant_q;
        end else if (m1_read) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_address_d  = s_address_q;
        data_d       = data_q;
        m0_rd_d      = m0_rd_q;
        m1_rd_d      = m1_rd_q;
        mismatch_d   = mismatch_q;
        count_d      = count_q;
        case (state_q)
            IDLE: begin
                if (m0_read || m1_read) begin
                    grant_d     = winner;
                    s_address_d = winner ? m1_address : m0_address;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                data_d = s_readdata;
                if (s_address_q && (s_readdata != EXPECTED_ID)) begin
                    mismatch_d = 1'b1;
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                if (grant_q) begin
                    m1_rd_d = data_q;
                end else begin
                    m0_rd_d = data_q;
                end
                last_grant_d = grant_q;
                count_d      = count_q + 16'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset masks the response pulse in the same cycle so an aborted
    // transfer never shows waitrequest low.
    assign resp0 = (state_q == RESPOND) && !grant_q && !reset;
    assign resp1 = (state_q == RESPOND) &&  grant_q && !reset;

    assign m0_waitrequest = ~resp0;
    assign m1_waitrequest = ~resp1;
    assign m0_readdata    = resp0 ? data_q : m0_rd_q;
    assign m1_readdata    = resp1 ? data_q : m1_rd_q;
    assign s_address      = s_address_q;
    assign busy           = (state_q != IDLE);
    assign id_mismatch    = mismatch_q;
    assign xfer_count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sysid_arbiter.sv
// ============================================================================
// Module   : tb_sysid_arbiter
// Brief    : Table-driven cycle trace plus directed corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sysid_arbiter;

    localparam logic [31:0] C_ID = 32'd1715151045;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_read, m0_address, m1_read, m1_address;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_address;
    logic [31:0] s_readdata;
    logic        busy, id_mismatch;
    logic [15:0] xfer_count;
    logic [31:0] id_val, ts_val;

    int checks = 0;
    int errors = 0;

    assign s_readdata = s_address ? id_val : ts_val;

    always #5 clock = ~clock;

    sysid_arbiter #(.EXPECTED_ID(C_ID)) dut (
        .clock          (clock),
        .reset          (reset),
        .m0_read        (m0_read),
        .m0_address     (m0_address),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_read        (m1_read),
        .m1_address     (m1_address),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .s_address      (s_address),
        .s_readdata     (s_readdata),
        .busy           (busy),
        .id_mismatch    (id_mismatch),
        .xfer_count     (xfer_count)
    );

    typedef struct {
        logic        rst, r0, a0, r1, a1;
        logic [31:0] idv, tsv;
        logic        wr0, wr1;
        logic [31:0] rd0, rd1;
        logic        bsy, mis;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, r0, a0, r1, a1,
                       input logic [31:0] idv, tsv,
                       input logic wr0, wr1,
                       input logic [31:0] rd0, rd1,
                       input logic bsy, mis,
                       input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
        v.idv = idv; v.tsv = tsv;
        v.wr0 = wr0; v.wr1 = wr1; v.rd0 = rd0; v.rd1 = rd1;
        v.bsy = bsy; v.mis = mis; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst, r0, a0, r1, a1, input logic [31:0] idv, tsv);
        reset = rst; m0_read = r0; m0_address = a0; m1_read = r1; m1_address = a1;
        id_val = idv; ts_val = tsv;
    endtask

    localparam logic [31:0] A = 32'hAAAA0001, B = 32'hBBBB0002;
    localparam logic [31:0] C = 32'hCCCC0003, D = 32'hDDDD0004;
    localparam logic [31:0] M = 32'h12345678;

    initial begin
        drive(1, 0, 0, 0, 0, C_ID, 0);
        tick; tick;
        chk("rst_wr0", {31'd0, m0_waitrequest}, 1);
        chk("rst_wr1", {31'd0, m1_waitrequest}, 1);
        chk("rst_cnt", {16'd0, xfer_count}, 0);
        chk("rst_saddr", {31'd0, s_address}, 0);

        //   rst r0 a0 r1 a1 idv  tsv            wr0 wr1 rd0   rd1  bsy mis cnt
        add(0, 1, 1, 0, 0, C_ID, 0,             1, 1, 0,    0,   0, 0, 0);
        add(0, 1, 1, 0, 0, C_ID, 0,             1, 1, 0,    0,   1, 0, 0);
        add(0, 1, 1, 0, 0, C_ID, 0,             0, 1, C_ID, 0,   1, 0, 0);
        add(0, 0, 0, 0, 0, C_ID, 0,             1, 1, C_ID, 0,   0, 0, 1);
        add(1, 0, 0, 0, 0, C_ID, 0,             1, 1, C_ID, 0,   0, 0, 1);
        add(0, 1, 0, 1, 0, C_ID, 0,             1, 1, 0,    0,   0, 0, 0);
        add(0, 1, 0, 1, 0, C_ID, 0,             1, 1, 0,    0,   1, 0, 0);
        add(0, 1, 0, 1, 0, C_ID, 0,             0, 1, 0,    0,   1, 0, 0);
        add(0, 0, 0, 1, 0, C_ID, 0,             1, 1, 0,    0,   0, 0, 1);
        add(0, 0, 0, 1, 0, C_ID, 0,             1, 1, 0,    0,   1, 0, 1);
        add(0, 0, 0, 1, 0, C_ID, 0,             1, 0, 0,    0,   1, 0, 1);
        add(0, 0, 0, 0, 0, C_ID, 0,             1, 1, 0,    0,   0, 0, 2);
        // sustained contention, 12 cycles
        add(0, 1, 0, 1, 0, C_ID, 0,             1, 1, 0,    0,   0, 0, 2);
        add(0, 1, 0, 1, 0, C_ID, A,             1, 1, 0,    0,   1, 0, 2);
        add(0, 1, 0, 1, 0, C_ID, 32'hFFFF0000,  0, 1, A,    0,   1, 0, 2);
        add(0, 1, 0, 1, 0, C_ID, 0,             1, 1, A,    0,   0, 0, 3);
        add(0, 1, 0, 1, 0, C_ID, B,             1, 1, A,    0,   1, 0, 3);
        add(0, 1, 0, 1, 0, C_ID, 0,             1, 0, A,    B,   1, 0, 3);
        add(0, 1, 0, 1, 0, C_ID, 0,             1, 1, A,    B,   0, 0, 4);
        add(0, 1, 0, 1, 0, C_ID, C,             1, 1, A,    B,   1, 0, 4);
        add(0, 1, 0, 1, 0, C_ID, 0,             0, 1, C,    B,   1, 0, 4);
        add(0, 1, 0, 1, 0, C_ID, 0,             1, 1, C,    B,   0, 0, 5);
        add(0, 1, 0, 1, 0, C_ID, D,             1, 1, C,    B,   1, 0, 5);
        add(0, 1, 0, 1, 0, C_ID, 0,             1, 0, C,    D,   1, 0, 5);
        add(0, 0, 0, 0, 0, C_ID, 0,             1, 1, C,    D,   0, 0, 6);
        // ID mismatch, then sticky through a correct ID read
        add(0, 0, 0, 1, 1, M,    0,             1, 1, C,    D,   0, 0, 6);
        add(0, 0, 0, 1, 1, M,    0,             1, 1, C,    D,   1, 0, 6);
        add(0, 0, 0, 1, 1, M,    0,             1, 0, C,    M,   1, 1, 6);
        add(0, 1, 1, 0, 0, C_ID, 0,             1, 1, C,    M,   0, 1, 7);
        add(0, 1, 1, 0, 0, C_ID, 0,             1, 1, C,    M,   1, 1, 7);
        add(0, 1, 1, 0, 0, C_ID, 0,             0, 1, C_ID, M,   1, 1, 7);
        add(0, 0, 0, 0, 0, C_ID, 0,             1, 1, C_ID, M,   0, 1, 8);
        add(1, 0, 0, 0, 0, C_ID, 0,             1, 1, C_ID, M,   0, 1, 8);
        add(0, 0, 0, 0, 0, C_ID, 0,             1, 1, 0,    0,   0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1, tbl[i].idv, tbl[i].tsv);
            #1;
            chk($sformatf("v%0d_wr0", i), {31'd0, m0_waitrequest}, {31'd0, tbl[i].wr0});
            chk($sformatf("v%0d_wr1", i), {31'd0, m1_waitrequest}, {31'd0, tbl[i].wr1});
            chk($sformatf("v%0d_rd0", i), m0_readdata, tbl[i].rd0);
            chk($sformatf("v%0d_rd1", i), m1_readdata, tbl[i].rd1);
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
            chk($sformatf("v%0d_mis", i), {31'd0, id_mismatch}, {31'd0, tbl[i].mis});
            chk($sformatf("v%0d_cnt", i), {16'd0, xfer_count}, {16'd0, tbl[i].cnt});
            tick;
        end

        // reset during ISSUE aborts; the retried request completes
        drive(0, 1, 0, 0, 0, C_ID, 32'h55);
        tick;
        chk("ri_busy", {31'd0, busy}, 1);
        reset = 1'b1; #1;
        chk("ri_wr0_a", {31'd0, m0_waitrequest}, 1);
        tick;
        chk("ri_wr0_b", {31'd0, m0_waitrequest}, 1);
        chk("ri_busy0", {31'd0, busy}, 0);
        chk("ri_cnt", {16'd0, xfer_count}, 0);
        reset = 1'b0;
        tick; tick;
        chk("ri_retry_wr0", {31'd0, m0_waitrequest}, 0);
        chk("ri_retry_rd0", m0_readdata, 32'h55);
        m0_read = 1'b0;
        tick;
        chk("ri_retry_cnt", {16'd0, xfer_count}, 1);

        // read dropped during ISSUE still gets its response pulse
        drive(0, 0, 0, 1, 0, C_ID, 32'h66);
        tick;
        m1_read = 1'b0;
        tick;
        chk("pv_wr1", {31'd0, m1_waitrequest}, 0);
        chk("pv_rd1", m1_readdata, 32'h66);
        tick;
        chk("pv_wr1_after", {31'd0, m1_waitrequest}, 1);
        chk("pv_cnt", {16'd0, xfer_count}, 2);

        // reset during RESPOND suppresses the pulse and the increment
        drive(0, 1, 0, 0, 0, C_ID, 32'h77);
        tick; tick;
        reset = 1'b1; #1;
        chk("rr_wr0", {31'd0, m0_waitrequest}, 1);
        m0_read = 1'b0;
        tick;
        reset = 1'b0;
        chk("rr_cnt", {16'd0, xfer_count}, 0);
        chk("rr_busy", {31'd0, busy}, 0);
        chk("rr_rd0", m0_readdata, 0);

        // counter wrap from a preloaded value
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        chk("wr_pre", {16'd0, xfer_count}, 32'h0000FFFE);
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 0, 0, C_ID, 32'h1);
            tick; tick;
            m0_read = 1'b0;
            tick;
        end
        chk("wr_wrap", {16'd0, xfer_count}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
